// File: rtl/vproc_vreg_reader.sv
// Read-side client of the vector register file: expands one register-group read
// request into a stream of PORT_W-wide beats buffered through a 2-entry FIFO.
module vproc_vreg_reader #(
   parameter int  VREG_W = 128,
   parameter int  PORT_W = 128,
   localparam int CHUNKS = VREG_W / PORT_W,
   localparam int CB     = $clog2(CHUNKS),
   localparam int AW     = 5 + CB
) (
   input  logic              clk_i,
   input  logic              async_rst_i,
   input  logic              flush_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [4:0]        req_vreg_i,
   input  logic [1:0]        req_emul_i,
   output logic              busy_o,
   output logic [AW-1:0]     rd_addr_o,
   input  logic [PORT_W-1:0] rd_data_i,
   output logic              data_valid_o,
   input  logic              data_ready_i,
   output logic [PORT_W-1:0] data_o,
   output logic              data_last_o
);

   typedef enum logic {
      IDLE,
      READ
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     addr_q;
   logic [AW-1:0]     last_addr_q;
   logic [4:0]        base_vreg;
   logic [AW-1:0]     base_addr;
   logic [AW-1:0]     nbeats_m1;
   logic              accept;
   logic              rd_issue;
   logic              beat_last;
   logic              pop;

   logic [PORT_W-1:0] fifo_data [2];
   logic [1:0]        fifo_last;
   logic              wr_ptr, rd_ptr;
   logic [1:0]        count;

   // Group base is aligned down to the group size, so the group never wraps past v31.
   always_comb begin
      base_vreg = req_vreg_i & (5'h1F << req_emul_i);
      base_addr = AW'(base_vreg) << CB;
      nbeats_m1 = AW'((CHUNKS << req_emul_i) - 1);
   end

   assign req_ready_o  = (state_q == IDLE) & ~flush_i;
   assign accept       = req_valid_i & req_ready_o;
   assign rd_issue     = (state_q == READ) & (count < 2'd2) & ~flush_i;
   assign beat_last    = (addr_q == last_addr_q);
   assign data_valid_o = (count != 2'd0);
   assign pop          = data_valid_o & data_ready_i & ~flush_i;
   assign data_o       = data_valid_o ? fifo_data[rd_ptr] : '0;
   assign data_last_o  = data_valid_o & fifo_last[rd_ptr];
   assign busy_o       = (state_q == READ) | data_valid_o;
   assign rd_addr_o    = addr_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = READ;
         READ: begin
            if (flush_i)                     state_d = IDLE;
            else if (rd_issue && beat_last)  state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) state_q <= IDLE;
      else             state_q <= state_d;
   end

   // The address stops on the final beat so rd_addr_o holds its last value while idle.
   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         addr_q      <= '0;
         last_addr_q <= '0;
      end else if (accept) begin
         addr_q      <= base_addr;
         last_addr_q <= base_addr + nbeats_m1;
      end else if (rd_issue && !beat_last) begin
         addr_q      <= addr_q + AW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge async_rst_i) begin
      if (async_rst_i) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last    <= '0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= '0;
      end else if (flush_i) begin
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         count        <= '0;
      end else begin
         if (rd_issue) begin
            fifo_data[wr_ptr] <= rd_data_i;
            fifo_last[wr_ptr] <= beat_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + 2'(rd_issue) - 2'(pop);
      end
   end

endmodule

// File: doc/vproc_vreg_reader.md
Name: vproc_vreg_reader

Overview:
- Read-side client of the multi-ported vector register file: turns a single "read register group" request into a stream of PORT_W-wide beats.
- For each beat it drives one register-file read port address and captures the same-cycle combinational read data into a 2-entry output FIFO.
- The FIFO feeds a valid/ready stream towards vector units (store path, reduction, slide).
- Sits between a dispatcher and one register-file read port.

Parameters:
- VREG_W, 128, vector register width in bits.
- PORT_W, 128, read port width in bits; power of two, divides VREG_W; CHUNKS = VREG_W/PORT_W.
- AW, 5+$clog2(VREG_W/PORT_W), register-file address width (derived, not overridable).

Ports:
- clk_i  in  1  clock, rising edge.
- async_rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous abort: drop request and FIFO contents.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_vreg_i  in  5  first vector register of group.
- req_emul_i  in  2  log2 group size (0..3 → 1,2,4,8 regs).
- busy_o  out  1  request in progress or FIFO non-empty.
- rd_addr_o  out  AW  register-file read address.
- rd_data_i  in  PORT_W  register-file read data, combinational from rd_addr_o.
- data_valid_o  out  1  output beat valid.
- data_ready_i  in  1  consumer ready.
- data_o  out  PORT_W  beat data.
- data_last_o  out  1  final beat of group.

Behaviour:
- Reset (async_rst_i=1, any time):
  - FSM → IDLE; counters and FIFO cleared.
  - req_ready_o=1, busy_o=0, data_valid_o=0, data_o=0, data_last_o=0, rd_addr_o=0.
- Addressing:
  - Base register = req_vreg_i with low req_emul_i bits forced to 0 (alignment); the group never wraps past v31.
  - Beat k (0 ≤ k < NBEATS, NBEATS = CHUNKS<<req_emul_i) reads address base*CHUNKS + k, in ascending order.
- FSM IDLE:
  - req_ready_o=1; rd_addr_o holds its last value.
  - On req_valid_i&req_ready_o: latch base and NBEATS, k=0, go to READ.
  - Acceptance is allowed while the FIFO still drains a previous group.
- FSM READ:
  - req_ready_o=0.
  - A read is issued in any cycle with FIFO count < 2. Count is the value at cycle start; a pop in the same cycle does not free a slot.
  - On a read: rd_data_i is pushed with last = (k == NBEATS-1), and k is incremented.
  - After pushing the last beat, go to IDLE the next cycle.
  - If no slot is free, rd_addr_o holds the current beat address.
- Latency: request accepted in cycle 0 → first read in cycle 1 → data_valid_o=1 with beat 0 in cycle 2.
- Throughput: with data_ready_i held 1, one beat per cycle in steady state.
- Back-to-back: the next request is accepted in the cycle after the last read, so there is one bubble cycle between groups.
- FIFO:
  - 2 entries, head drives data_o/data_last_o; data_o and data_last_o are 0 when empty.
  - Pop on data_valid_o&data_ready_i. Push and pop may occur in the same cycle.
  - Overflow is impossible by the issue rule.
- Stream rule: once data_valid_o=1, data_o and data_last_o stay stable until the beat is accepted.
- busy_o = (state==READ) | (FIFO count != 0).
- flush_i:
  - Next cycle: IDLE, FIFO empty, data_valid_o=0.
  - A request presented in the same cycle as flush_i is not accepted (req_ready_o forced 0 while flush_i=1).
  - flush_i takes priority over pushes and pops.
- rd_data_i is sampled only in cycles where a read is issued.

Test Plan:
- VREG_W=128, PORT_W=32 (CHUNKS=4, AW=7), vreg=4, emul=1, data_ready_i=1 → rd_addr_o 16..23 in cycles 1..8; 8 beats in cycles 2..9; data_last_o only on beat 7; busy_o falls in cycle 10.
- Same config, vreg=7, emul=2 → base realigned to v4; 16 beats, addresses 16..31.
- data_ready_i=0 for 5 cycles after request → exactly 2 reads issued, rd_addr_o stalls at 18; data_o holds beat 0. When data_ready_i is released, the beat order 0..7 is intact with no duplicates or losses.
- Two requests back-to-back (v0 emul=0, then v8 emul=0) → second accepted in the cycle after the first's last read; output 8 beats in order, with data_last_o on beats 3 and 7.
- flush_i asserted mid-group with 2 beats buffered → next cycle data_valid_o=0, busy_o=0, req_ready_o=1; a new request then streams correctly.
- async_rst_i pulsed mid-stream, asynchronous to clk_i → outputs go to reset values immediately, with no further beats emitted.
